// File: rtl/cipher_bit_packer_if.sv
// ============================================================================
// Module  : cipher_bit_packer_if
// Purpose : Bit-stream input, word output and frame control bundle for
//           cipher_bit_packer. word_parity exists only with PACKER_PARITY_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface cipher_bit_packer_if #(
    parameter int WORD_W = 8
);
    logic              bit_in;
    logic              bit_valid;
    logic              start;
    logic              flush;
    logic [WORD_W-1:0] word_out;
    logic [4:0]        word_len;
    logic              word_valid;
    logic              word_ready;
    logic              busy;
    logic              overflow;
`ifdef PACKER_PARITY_EN
    logic              word_parity;

    modport master (
        input  bit_in, bit_valid, start, flush, word_ready,
        output word_out, word_len, word_valid, busy, overflow, word_parity
    );

    modport slave (
        output bit_in, bit_valid, start, flush, word_ready,
        input  word_out, word_len, word_valid, busy, overflow, word_parity
    );
`else
    modport master (
        input  bit_in, bit_valid, start, flush, word_ready,
        output word_out, word_len, word_valid, busy, overflow
    );

    modport slave (
        output bit_in, bit_valid, start, flush, word_ready,
        input  word_out, word_len, word_valid, busy, overflow
    );
`endif
endinterface

`default_nettype wire

// File: rtl/cipher_bit_packer.sv
// ============================================================================
// Module  : cipher_bit_packer
// Purpose : Packs a serial ciphertext bit stream into WORD_W-bit words behind
//           a 2-entry valid/ready buffer. Optional macro PACKER_PARITY_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module cipher_bit_packer #(
    parameter int WORD_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    cipher_bit_packer_if.master   bus
);

    localparam logic [4:0] LEN_FULL = 5'(WORD_W);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] data;
        logic [4:0]        len;
`ifdef PACKER_PARITY_EN
        logic              par;
`endif
    } entry_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [4:0]        count;
    entry_t            ent0;
    entry_t            ent1;
    logic              ovf;

    logic              take_bit;
    logic [WORD_W-1:0] shreg_nxt;
    logic [4:0]        count_nxt;
    logic [4:0]        gap;
    logic              push;
    logic              drain;
    entry_t            push_ent;

    // Received bits sit at the low end (MSB-first) or high end (LSB-first)
    // of the shift register; the final shift aligns and zero-pads them.
    always_comb begin
        take_bit  = (state == S_COLLECT) && bus.bit_valid;
        shreg_nxt = shreg;
        if (take_bit) begin
            if (MSB_FIRST)
                shreg_nxt = {shreg[WORD_W-2:0], bus.bit_in};
            else
                shreg_nxt = {bus.bit_in, shreg[WORD_W-1:1]};
        end
        count_nxt = count + {4'd0, take_bit};
        gap       = LEN_FULL - count_nxt;
        push      = (state == S_COLLECT) &&
                    ((count_nxt == LEN_FULL) || (bus.flush && (count_nxt != 5'd0)));
        drain     = ent0.valid && bus.word_ready;

        push_ent       = '0;
        push_ent.valid = 1'b1;
        push_ent.len   = count_nxt;
        if (MSB_FIRST)
            push_ent.data = shreg_nxt << gap;
        else
            push_ent.data = shreg_nxt >> gap;
`ifdef PACKER_PARITY_EN
        push_ent.par = ^push_ent.data;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            count <= '0;
            shreg <= '0;
            ent0  <= '0;
            ent1  <= '0;
            ovf   <= 1'b0;
        end else begin
            if (drain) begin
                if (ent1.valid) begin
                    ent0 <= ent1;
                    ent1 <= push ? push_ent : '0;
                end else begin
                    ent0 <= push ? push_ent : '0;
                end
            end else if (push) begin
                if (!ent0.valid)
                    ent0 <= push_ent;
                else if (!ent1.valid)
                    ent1 <= push_ent;
                else
                    ovf <= 1'b1;
            end

            // start is applied after any flush push, so it also wins on overflow
            if (bus.start) begin
                state <= S_COLLECT;
                count <= '0;
                shreg <= '0;
                ovf   <= 1'b0;
            end else if ((state == S_COLLECT) && bus.flush) begin
                state <= S_IDLE;
                count <= '0;
                shreg <= '0;
            end else if (push) begin
                count <= '0;
                shreg <= '0;
            end else begin
                count <= count_nxt;
                shreg <= shreg_nxt;
            end
        end
    end

    assign bus.word_out   = ent0.data;
    assign bus.word_len   = ent0.len;
    assign bus.word_valid = ent0.valid;
    assign bus.busy       = (state == S_COLLECT);
    assign bus.overflow   = ovf;
`ifdef PACKER_PARITY_EN
    assign bus.word_parity = ent0.par;
`endif

endmodule

`default_nettype wire
